ram: RTL and testbench

- Single-port synchronous RAM, flop-based array of 2**addr_width words of data_width bits.
- Registered read port and a synchronous write port share one address bus.
- Asynchronous active-low reset clears the whole array and the output register.
- Serves as a small scratchpad or register-file store inside the datapath.

---
 rtl/ram.sv | 73 +++++++
 tb/tb_ram.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ram.sv
// Single-port flop-based RAM: registered read, synchronous write, async reset.
// Define RAM_PARITY_EN to store an even-parity bit per word and flag mismatches.
module ram #(
  parameter int data_width = 8,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] in,
  output logic [data_width-1:0] out,
  output logic                  parity_err
);

  localparam int depth = 2 ** addr_width;
`ifdef RAM_PARITY_EN
  localparam int ww = data_width + 1;
`else
  localparam int ww = data_width;
`endif

  logic [ww-1:0]         mem_q [depth];
  logic [ww-1:0]         wr_d;
  logic [ww-1:0]         rd_d;
  logic [data_width-1:0] out_q;

  always_comb begin
    rd_d = mem_q[addr];
`ifdef RAM_PARITY_EN
    wr_d = {^in, in};
`else
    wr_d = in;
`endif
  end

  // Read samples the pre-write word, giving read-before-write on collisions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
      out_q <= '0;
    end else begin
      if (we == 1'b1) begin
        mem_q[addr] <= wr_d;
      end
      if (re == 1'b1) begin
        out_q <= rd_d[data_width-1:0];
      end
    end
  end

  assign out = out_q;

`ifdef RAM_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_q <= 1'b0;
    end else if (re == 1'b1) begin
      perr_q <= ^rd_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram (7-bit words, 32 entries).
// Directed plan plus random traffic against an array-based reference.
module tb_ram;

  localparam int DW = 7;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic          we;
  logic          re;
  logic [AW-1:0] addr;
  logic [DW-1:0] in;
  logic [DW-1:0] out;
  logic          parity_err;

  int            n_cmp;
  int            n_err;
  logic [DW-1:0] model [DEPTH];
  bit            bad   [DEPTH];
  logic [DW-1:0] exp_out;
  logic          exp_perr;

  ram #(
    .data_width(DW),
    .addr_width(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .re        (re),
    .addr      (addr),
    .in        (in),
    .out       (out),
    .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      bad[i]   = 1'b0;
    end
    exp_out  = '0;
    exp_perr = 1'b0;
  endtask

  // One clock of traffic; the model reads old contents before writing.
  task automatic step(input bit w, input bit r, input int a, input int d,
                      input string tag);
    we   = w;
    re   = r;
    addr = a[AW-1:0];
    in   = d[DW-1:0];
    @(posedge clk);
    #1;
    if (r) begin
      exp_out  = model[a];
      exp_perr = bad[a];
    end
    if (w) begin
      model[a] = d[DW-1:0];
      bad[a]   = 1'b0;
    end
    chk({tag, ".out"}, {1'b0, out}, {1'b0, exp_out});
    chk({tag, ".perr"}, {7'd0, parity_err}, {7'd0, exp_perr});
    we = 1'b0;
    re = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_clear();
    rst  = 1'b0;
    we   = 1'b1;
    re   = 1'b0;
    addr = '0;
    in   = 7'h55;
    #1;
    chk("rst_out", {1'b0, out}, 8'h00);
    chk("rst_perr", {7'd0, parity_err}, 8'h00);
    #3;
    we  = 1'b0;
    rst = 1'b1;
    step(0, 1, 3, 0, "post_rst");

    for (int i = 0; i < 5; i++) step(1, 0, i, i, "sweep_wr");
    for (int i = 0; i < 5; i++) begin
      step(0, 1, i, 0, "sweep_rd");
      chk("sweep_val", {1'b0, out}, 8'(i));
    end

    for (int i = 0; i < DEPTH; i++) step(1, 0, i, ~i & 7'h7f, "full_wr");
    step(0, 1, 31, 0, "full31");
    chk("full31_k", {1'b0, out}, 8'h60);
    step(0, 1, 0, 0, "full0");
    chk("full0_k", {1'b0, out}, 8'h7f);

    step(1, 0, 9, 'h12, "col_init");
    step(1, 1, 9, 'h34, "col");
    chk("col_old", {1'b0, out}, 8'h12);
    step(0, 1, 9, 0, "col_new");
    chk("col_new_k", {1'b0, out}, 8'h34);

    step(1, 1, 4, 'h11, "diff_wr");
    step(1, 1, 5, 'h22, "diff_both");
    chk("diff_rd_k", {1'b0, out}, 8'h7a);

    step(1, 0, 2, 2, "hold_wr");
    step(0, 1, 2, 0, "hold_rd");
    for (int i = 0; i < 5; i++) begin
      step(0, 0, $urandom_range(DEPTH - 1), 0, "hold");
      chk("hold_k", {1'b0, out}, 8'h02);
    end

    rst = 1'b0;
    #1;
    chk("mid_rst_out", {1'b0, out}, 8'h00);
    chk("mid_rst_perr", {7'd0, parity_err}, 8'h00);
    model_clear();
    #1;
    rst = 1'b1;
    step(0, 1, 2, 0, "after_rst");
    chk("after_rst_k", {1'b0, out}, 8'h00);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), $urandom_range(DEPTH - 1),
           $urandom_range(127), "rand");
    end

`ifdef RAM_PARITY_EN
    step(1, 0, 1, 'h7f, "par_wr");
    step(0, 1, 1, 0, "par_rd");
    chk("par_ok", {7'd0, parity_err}, 8'h00);
    dut.mem_q[1] = dut.mem_q[1] ^ 8'h01;
    model[1] = model[1] ^ 7'h01;
    bad[1]   = 1'b1;
    step(0, 1, 1, 0, "par_flip");
    chk("par_flip_k", {7'd0, parity_err}, 8'h01);
    chk("par_flip_d", {1'b0, out}, 8'h7e);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
